axi_lite_cmd_arbiter: RTL and testbench
=======================================

Name: axi_lite_cmd_arbiter

Overview:
Shares the single AXI-lite master command port (start_read/start_write/addr/data/wstrb) among NUM_REQ requesters, for example the CPU load/store path and a UART status-poll engine. It arbitrates round-robin and sequences exactly one transaction at a time through the master. It returns read data and error status to the granted requester, and bounds every transaction with a timeout. It sits directly upstream of axi_lite_master in top.

Parameters:
NUM_REQ, 2, number of requesters (1..4)
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 1024, WAIT-state cycle limit before error completion; 0 disables the timeout

Ports:
aclk  in  1  clock
areset_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
req_wstrb  in  NUM_REQ*4  flattened byte strobes
req_ready  out  NUM_REQ  command accepted (one-hot)
rsp_valid  out  NUM_REQ  one-cycle completion pulse (one-hot)
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  error completion, qualified by rsp_valid
start_read  out  1  one-cycle read start to the master
start_write  out  1  one-cycle write start to the master
addr  out  ADDR_W  latched address to the master
data  out  DATA_W  latched write data to the master
wstrb  out  4  latched strobes to the master
m_done  in  1  master completion pulse (B or R handshake done)
m_rdata  in  DATA_W  master read data, valid with m_done
m_resp  in  2  BRESP/RRESP, valid with m_done
busy  out  1  state != IDLE
grant_id  out  2  index of the current or last granted requester
state  out  3  debug encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3, DRAIN=4

Behaviour:
- Reset (areset_n low at a rising edge):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs are 0: start_*, req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data, wstrb.
  - A reset asserted mid-transaction abandons it; no rsp_valid is issued.
- Requester rule: hold write, addr, wdata and wstrb stable while valid is high until the ready cycle. valid may drop before acceptance without effect.
- IDLE:
  - Grant g = first requester with req_valid, searching from rr_ptr upward with wrap.
  - req_ready[g] is combinational and high only in IDLE for the winner.
  - Acceptance is req_valid[g] & req_ready[g]. On acceptance, latch the command into addr/data/wstrb and a write flag, set grant_id=g, and go to ISSUE.
  - For a read, data and wstrb latch as 0.
- ISSUE (exactly 1 cycle): start_write=flag or start_read=!flag is high. Go to WAIT and clear the timeout counter.
- WAIT:
  - The counter increments each cycle.
  - On m_done: capture rsp_rdata=(read ? m_rdata : 0) and rsp_err=(m_resp!=0), then go to RESP.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without m_done: rsp_rdata=0, rsp_err=1, set the pending-drain flag, go to RESP.
  - m_done takes priority if it coincides with the timeout cycle.
- RESP (exactly 1 cycle):
  - rsp_valid[grant_id]=1; there is no backpressure.
  - rr_ptr = (grant_id+1) mod NUM_REQ.
  - Next state is DRAIN if the pending-drain flag is set, else IDLE.
- DRAIN: wait for m_done, discard its data, clear the flag, go to IDLE. This prevents overlapping master transactions.
- m_done is ignored in IDLE, ISSUE and RESP.
- addr/data/wstrb hold their values from acceptance until the next acceptance.
- Latency:
  - Acceptance in cycle N gives start_* in N+1.
  - m_done in cycle M (M >= N+2) gives rsp_valid in M+1.
  - The minimum accept-to-accept spacing is 4 cycles.
- Simultaneous requests resolve round-robin, so no requester waits more than NUM_REQ-1 transactions.
- NUM_REQ=1: rr_ptr is held at 0.

Test Plan:
- Single read: req 0 reads 0x0000_0004; m_done 3 cycles after start with m_rdata=0x0000_00A5 and m_resp=0 -> start_read pulses once, addr=0x4, rsp_valid[0] pulses one cycle later, rsp_rdata=0xA5, rsp_err=0.
- Write: req 1 writes 0x55 to 0x8 with wstrb=4'hF -> start_write pulses with data=0x55, wstrb=F; rsp_valid[1], rsp_rdata=0, rsp_err=0.
- Contention: both requesters hold req_valid after reset -> grant order 0,1,0,1 across four transactions; req_ready is never high for both in the same cycle.
- Error: m_resp=2'b10 on m_done -> rsp_err=1 for the granted requester.
- Timeout with TIMEOUT=8: m_done withheld -> rsp_valid with rsp_err=1 and rdata=0 eight WAIT cycles after start; state=DRAIN; req_ready stays 0 until an m_done is injected, then IDLE and the next grant proceeds.
- Reset in WAIT: areset_n low for 1 cycle -> state=0, busy=0, no rsp_valid; a later m_done is ignored; a new request succeeds.

Source files
------------

// File: rtl/axi_lite_cmd_arbiter.sv
// axi_lite_cmd_arbiter
// Round-robin arbiter that shares one AXI-lite master command port among
// NUM_REQ requesters and runs exactly one transaction at a time.
//
// Ports:
//   aclk, areset_n       clock, synchronous active-low reset
//   req_valid/req_write  per-requester command valid and direction (1 = write)
//   req_addr/wdata/wstrb flattened per-requester command fields
//   req_ready            one-hot command accept (combinational, IDLE only)
//   rsp_valid            one-hot one-cycle completion pulse
//   rsp_rdata, rsp_err   completion data / error, qualified by rsp_valid
//   start_read/write     one-cycle start pulse to the master
//   addr, data, wstrb    command latched at acceptance, held until the next one
//   m_done/m_rdata/m_resp master completion pulse with read data and response
//   busy, grant_id, state debug / status
module axi_lite_cmd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]      req_wstrb,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      start_read,
  output logic                      start_write,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         data,
  output logic [3:0]                wstrb,
  input  logic                      m_done,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_resp,
  output logic                      busy,
  output logic [1:0]                grant_id,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t              state_reg, state_next;
  logic [1:0]          rr_ptr_reg;
  logic [1:0]          grant_id_reg;
  logic                write_reg;
  logic                drain_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [3:0]          wstrb_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                rsp_err_reg;

  logic [3:0]          valid_pad;
  logic [2:0]          cand;
  logic [1:0]          grant_idx;
  logic                grant_found;
  logic                accept;
  logic                timeout_hit;

  // Round-robin search starting at rr_ptr; cand never exceeds 2*NUM_REQ-2,
  // so a single conditional subtract implements the wrap.
  always_comb begin
    valid_pad   = 4'(req_valid);
    grant_found = 1'b0;
    grant_idx   = rr_ptr_reg;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 3'(rr_ptr_reg) + 3'(k);
      if (cand >= 3'(NUM_REQ)) begin
        cand = cand - 3'(NUM_REQ);
      end
      if (!grant_found && valid_pad[cand[1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[1:0];
      end
    end
  end

  assign accept      = (state_reg == IDLE) && grant_found;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_ready[gi] = areset_n && accept && (grant_idx == 2'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (grant_id_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_read  = 1'b0;
    start_write = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        start_write = write_reg;
        start_read  = !write_reg;
        state_next  = WAIT;
      end
      WAIT: begin
        // m_done wins over a coincident timeout: both leave for RESP,
        // but only the timeout sets the drain flag.
        if (m_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        state_next = drain_reg ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (m_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rr_ptr_reg    <= '0;
      grant_id_reg  <= '0;
      write_reg     <= 1'b0;
      drain_reg     <= 1'b0;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      wstrb_reg     <= '0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            grant_id_reg <= grant_idx;
            write_reg    <= req_write[grant_idx];
            addr_reg     <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            if (req_write[grant_idx]) begin
              data_reg  <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
              wstrb_reg <= req_wstrb[int'(grant_idx)*4 +: 4];
            end else begin
              data_reg  <= '0;
              wstrb_reg <= '0;
            end
          end
        end
        ISSUE: begin
          cnt_reg <= '0;
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (m_done) begin
            rsp_rdata_reg <= write_reg ? '0 : m_rdata;
            rsp_err_reg   <= (m_resp != 2'b00);
          end else if (timeout_hit) begin
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
            drain_reg     <= 1'b1;
          end
        end
        RESP: begin
          if (NUM_REQ == 1) begin
            rr_ptr_reg <= '0;
          end else if (grant_id_reg == 2'(NUM_REQ - 1)) begin
            rr_ptr_reg <= '0;
          end else begin
            rr_ptr_reg <= grant_id_reg + 2'd1;
          end
        end
        DRAIN: begin
          // The late completion of the timed-out transaction is discarded.
          if (m_done) drain_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign addr      = addr_reg;
  assign data      = data_reg;
  assign wstrb     = wstrb_reg;
  assign busy      = (state_reg != IDLE);
  assign grant_id  = grant_id_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Testbench for axi_lite_cmd_arbiter: table-driven single transactions,
// hand-written contention / timeout / reset sequences, and randomized
// traffic checked against a transaction-level round-robin model.
module tb_axi_lite_cmd_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            aclk = 1'b0;
  logic            areset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_wstrb = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            start_read;
  logic            start_write;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   data;
  logic [3:0]      wstrb;
  logic            m_done = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic [1:0]      m_resp = '0;
  logic            busy;
  logic [1:0]      grant_id;
  logic [2:0]      state;

  axi_lite_cmd_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .start_read(start_read), .start_write(start_write),
    .addr(addr), .data(data), .wstrb(wstrb),
    .m_done(m_done), .m_rdata(m_rdata), .m_resp(m_resp),
    .busy(busy), .grant_id(grant_id), .state(state)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 0;

  logic        c_wr[N];
  logic [31:0] c_addr[N];
  logic [31:0] c_data[N];
  logic [3:0]  c_strb[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_reqs(input logic [N-1:0] mask);
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_write[i]           = c_wr[i];
      req_addr[i*AW +: AW]   = c_addr[i];
      req_wdata[i*DW +: DW]  = c_data[i];
      req_wstrb[i*4 +: 4]    = c_strb[i];
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (model_ptr + k) % N;
      if (mask[idx]) return idx;
    end
    return 0;
  endfunction

  // Invariants checked every cycle outside reset.
  always @(negedge aclk) begin
    if (areset_n) begin
      check("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
      check("rsp_onehot0", 32'($countones(rsp_valid) <= 1), 32'd1);
      if (state != 3'd0) check("ready_only_idle", 32'(req_ready), 32'd0);
    end
  end

  // One complete transaction starting in IDLE. Losing requesters stay valid.
  task automatic txn(input logic [N-1:0] mask, input int exp_id, input int dly,
                     input logic [31:0] mrd, input logic [1:0] mresp, input bit withhold,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [N-1:0] oh;
    logic wr;
    oh = '0;
    oh[exp_id] = 1'b1;
    wr = c_wr[exp_id];
    drive_reqs(mask);
    #1;
    check("idle_state", 32'(state), 32'd0);
    check("ready_grant", 32'(req_ready), 32'(oh));
    tick();
    req_valid = mask & ~oh;
    check("issue_state", 32'(state), 32'd1);
    check("start_write", 32'(start_write), 32'(wr));
    check("start_read", 32'(start_read), 32'(!wr));
    check("grant_id", 32'(grant_id), 32'(exp_id));
    check("addr", addr, c_addr[exp_id]);
    check("data", data, wr ? c_data[exp_id] : 32'h0);
    check("wstrb", 32'(wstrb), wr ? 32'(c_strb[exp_id]) : 32'h0);
    if (withhold) begin
      for (int i = 1; i <= TO; i++) begin
        tick();
        check("wait_state", 32'(state), 32'd2);
        check("no_early_rsp", 32'(rsp_valid), 32'd0);
      end
    end else begin
      for (int i = 1; i <= dly; i++) begin
        tick();
        check("wait_state", 32'(state), 32'd2);
        check("no_early_rsp", 32'(rsp_valid), 32'd0);
        if (i == dly) begin
          m_done  = 1'b1;
          m_rdata = mrd;
          m_resp  = mresp;
        end
      end
    end
    tick();
    m_done  = 1'b0;
    m_rdata = '0;
    m_resp  = '0;
    check("resp_state", 32'(state), 32'd3);
    check("rsp_valid", 32'(rsp_valid), 32'(oh));
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    model_ptr = (exp_id + 1) % N;
    tick();
    if (withhold) begin
      check("drain_state", 32'(state), 32'd4);
      check("drain_no_ready", 32'(req_ready), 32'd0);
      tick();
      check("drain_hold", 32'(state), 32'd4);
      check("drain_no_rsp", 32'(rsp_valid), 32'd0);
      m_done  = 1'b1;
      m_rdata = 32'hBAD0_BAD0;
      m_resp  = 2'b10;
      tick();
      m_done  = 1'b0;
      m_rdata = '0;
      m_resp  = '0;
      check("post_drain_idle", 32'(state), 32'd0);
      check("post_drain_no_rsp", 32'(rsp_valid), 32'd0);
    end else begin
      check("back_to_idle", 32'(state), 32'd0);
      check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    end
  endtask

  typedef struct {
    int          id;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          dly;
    logic [31:0] mrd;
    logic [1:0]  mresp;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [N-1:0] mask;
    logic [1:0]   mr;
    logic [31:0]  rd;
    int           w, dly;
    bit           wh;
    int           order[4];

    tbl[0] = '{0, 1'b0, 32'h0000_0004, 32'h0,         4'h0, 3, 32'h0000_00A5, 2'b00, 32'h0000_00A5, 1'b0};
    tbl[1] = '{1, 1'b1, 32'h0000_0008, 32'h0000_0055, 4'hF, 2, 32'hDEAD_BEEF, 2'b00, 32'h0,         1'b0};
    tbl[2] = '{0, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 1, 32'h1234_5678, 2'b10, 32'h1234_5678, 1'b1};
    tbl[3] = '{1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'h5, 5, 32'h0,         2'b11, 32'h0,         1'b1};
    tbl[4] = '{0, 1'b1, 32'h0000_0010, 32'h0BAD_CAFE, 4'h3, 4, 32'h0,         2'b01, 32'h0,         1'b1};
    tbl[5] = '{1, 1'b0, 32'h0000_0020, 32'h0,         4'h0, TO-1, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF, 1'b0};
    tbl[6] = '{0, 1'b0, 32'h0000_0024, 32'h0,         4'h0, TO, 32'h0000_5A5A, 2'b00, 32'h0000_5A5A, 1'b0};
    for (int i = 0; i < N; i++) begin
      c_wr[i] = 1'b0; c_addr[i] = '0; c_data[i] = '0; c_strb[i] = '0;
    end

    // Reset state
    areset_n = 1'b0;
    repeat (3) tick();
    areset_n = 1'b1;
    tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_start", 32'({start_read, start_write}), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    model_ptr = 0;

    // Table-driven single-requester transactions
    for (int t = 0; t < 7; t++) begin
      c_wr[tbl[t].id]   = tbl[t].wr;
      c_addr[tbl[t].id] = tbl[t].a;
      c_data[tbl[t].id] = tbl[t].wd;
      c_strb[tbl[t].id] = tbl[t].strb;
      mask = '0;
      mask[tbl[t].id] = 1'b1;
      txn(mask, tbl[t].id, tbl[t].dly, tbl[t].mrd, tbl[t].mresp, 1'b0,
          tbl[t].exp_rd, tbl[t].exp_err);
      req_valid = '0;
      $display("vector %0d: req %0d %s addr=%h rdata=%h err=%0d", t, tbl[t].id,
               tbl[t].wr ? "write" : "read", tbl[t].a, tbl[t].exp_rd, tbl[t].exp_err);
    end

    // Contention after reset: grant order 0,1,0,1
    areset_n = 1'b0;
    tick();
    areset_n = 1'b1;
    tick();
    model_ptr = 0;
    c_wr[0] = 1'b0; c_addr[0] = 32'h0000_0040; c_data[0] = '0; c_strb[0] = '0;
    c_wr[1] = 1'b1; c_addr[1] = 32'h0000_0080; c_data[1] = 32'h1111_2222; c_strb[1] = 4'hC;
    order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
    for (int t = 0; t < 4; t++) begin
      txn(2'b11, order[t], 2, 32'h0000_0A00 + 32'(t), 2'b00, 1'b0,
          (order[t] == 0) ? 32'h0000_0A00 + 32'(t) : 32'h0, 1'b0);
      $display("contention %0d: granted req %0d", t, order[t]);
    end
    req_valid = '0;

    // Timeout: req 0 read with m_done withheld, req 1 waiting through DRAIN
    c_wr[0] = 1'b0; c_addr[0] = 32'h0000_0C00;
    txn(2'b11, 0, 0, 32'h0, 2'b00, 1'b1, 32'h0, 1'b1);
    $display("timeout: req 0 error completion, drain done");
    txn(2'b11, 1, 3, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
    $display("timeout: req 1 granted after drain");
    req_valid = '0;

    // Reset while in WAIT
    c_wr[0] = 1'b0; c_addr[0] = 32'h0000_0D00;
    drive_reqs(2'b01);
    tick();
    req_valid = '0;
    tick();
    tick();
    check("pre_rst_wait", 32'(state), 32'd2);
    areset_n = 1'b0;
    tick();
    check("rst_wait_state", 32'(state), 32'd0);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_wait_addr", addr, 32'd0);
    areset_n = 1'b1;
    tick();
    m_done = 1'b1;
    m_rdata = 32'h7777_7777;
    tick();
    m_done = 1'b0;
    m_rdata = '0;
    check("late_done_ignored", 32'(state), 32'd0);
    check("late_done_no_rsp", 32'(rsp_valid), 32'd0);
    model_ptr = 0;
    c_wr[1] = 1'b0; c_addr[1] = 32'h0000_0E00;
    txn(2'b10, 1, 2, 32'h0000_3C3C, 2'b00, 1'b0, 32'h0000_3C3C, 1'b0);
    $display("reset-in-wait: recovery transaction ok");
    req_valid = '0;

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        c_wr[i]   = 1'($urandom_range(0, 1));
        c_addr[i] = $urandom & 32'hFFFF_FFFC;
        c_data[i] = $urandom;
        c_strb[i] = 4'($urandom);
      end
      w   = rr_pick(mask);
      wh  = ($urandom_range(0, 7) == 0);
      dly = $urandom_range(1, TO);
      rd  = $urandom;
      mr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      txn(mask, w, dly, rd, mr, wh,
          (wh || c_wr[w]) ? 32'h0 : rd, wh || (mr != 2'b00));
      $display("random %0d: mask=%b grant=%0d %s dly=%0d timeout=%0d", t, mask, w,
               c_wr[w] ? "write" : "read", dly, wh);
    end
    req_valid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
